packet_st_gen_mm: RTL and testbench

Avalon-MM slave holding the control/status register file of the packet streaming generator. The system master programs and reads back generator settings through this port. Every accepted access is followed by a fixed busy window signalled on `waitrequest`, which paces the master. The block is purely a register/handshake endpoint and has no streaming outputs of its own.

---
 rtl/packet_st_gen_mm_pkg.sv | 19 +
 rtl/packet_st_gen_mm_if.sv | 29 ++
 rtl/packet_st_gen_mm_regs.sv | 35 +++
 rtl/packet_st_gen_mm.sv | 75 +++++++
 tb/tb_packet_st_gen_mm.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/packet_st_gen_mm_pkg.sv
// rtl/packet_st_gen_mm_pkg.sv - shared constants, FSM encoding and address decode helper
package packet_st_gen_mm_pkg;

   localparam logic [7:0] ADDR_ID   = 8'h00;
   localparam logic [7:0] ADDR_LAST = 8'h0F;
   localparam logic [7:0] ID_VALUE  = 8'h5A;

   typedef enum logic [1:0] {
      RST  = 2'd0,
      IDLE = 2'd1,
      BUSY = 2'd2
   } state_t;

   // True for the writable window 0x01..0x0F; ID and unmapped space excluded.
   function automatic logic is_rw_addr(input logic [7:0] addr);
      return (addr != ADDR_ID) && (addr <= ADDR_LAST);
   endfunction

endpackage

// File: rtl/packet_st_gen_mm_if.sv
// rtl/packet_st_gen_mm_if.sv - memory-mapped register bus between system master and generator CSRs
interface packet_st_gen_mm_if;

   logic [7:0] address;
   logic       write;
   logic       read;
   logic [7:0] writedata;
   logic       waitrequest;
   logic [7:0] readdata;

   modport master (
      output address,
      output write,
      output read,
      output writedata,
      input  waitrequest,
      input  readdata
   );

   modport slave (
      input  address,
      input  write,
      input  read,
      input  writedata,
      output waitrequest,
      output readdata
   );

endinterface

// File: rtl/packet_st_gen_mm_regs.sv
// rtl/packet_st_gen_mm_regs.sv - 15x8 R/W register file with ID constant and unmapped decode
module packet_st_gen_mm_regs
   import packet_st_gen_mm_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       we,
   input  logic [7:0] waddr,
   input  logic [7:0] wdata,
   input  logic [7:0] raddr,
   output logic [7:0] rdata
);

   logic [7:0] mem [1:15];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 1; i <= 15; i++) begin
            mem[i] <= 8'h00;
         end
      end else if (we && is_rw_addr(waddr)) begin
         mem[waddr[3:0]] <= wdata;
      end
   end

   always_comb begin
      rdata = 8'h00;
      if (raddr == ADDR_ID) begin
         rdata = ID_VALUE;
      end else if (is_rw_addr(raddr)) begin
         rdata = mem[raddr[3:0]];
      end
   end

endmodule

// File: rtl/packet_st_gen_mm.sv
// rtl/packet_st_gen_mm.sv - CSR slave: accept in IDLE, then hold waitrequest for WAIT_CYCLES
module packet_st_gen_mm
   import packet_st_gen_mm_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = 2
)(
   input  logic               clk,
   input  logic               reset,
   packet_st_gen_mm_if.slave  bus
);

   state_t     state;
   state_t     state_nx;
   logic [3:0] cnt;
   logic [3:0] cnt_nx;
   logic       accept;
   logic [7:0] reg_rdata;

   packet_st_gen_mm_regs u_regs (
      .clk   (clk),
      .reset (reset),
      .we    (accept && bus.write),
      .waddr (bus.address),
      .wdata (bus.writedata),
      .raddr (bus.address),
      .rdata (reg_rdata)
   );

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      accept   = 1'b0;
      case (state)
         RST: begin
            state_nx = IDLE;
         end
         IDLE: begin
            if (bus.read || bus.write) begin
               accept   = 1'b1;
               state_nx = BUSY;
               cnt_nx   = WAIT_CYCLES[3:0];
            end
         end
         BUSY: begin
            if (cnt <= 4'd1) begin
               state_nx = IDLE;
               cnt_nx   = 4'd0;
            end else begin
               cnt_nx = cnt - 4'd1;
            end
         end
         default: begin
            state_nx = RST;
         end
      endcase
   end

   // waitrequest tracks the next state so it changes on the same edge as the FSM.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= RST;
         cnt             <= 4'd0;
         bus.waitrequest <= 1'b1;
         bus.readdata    <= 8'h00;
      end else begin
         state           <= state_nx;
         cnt             <= cnt_nx;
         bus.waitrequest <= (state_nx != IDLE);
         if (accept && bus.read) begin
            bus.readdata <= reg_rdata;
         end
      end
   end

endmodule

// File: tb/tb_packet_st_gen_mm.sv
// tb/tb_packet_st_gen_mm.sv - directed scoreboard bench for the generator CSR slave
module tb_packet_st_gen_mm;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   packet_st_gen_mm_if bus ();

   packet_st_gen_mm #(.WAIT_CYCLES(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, expv, $time);
      end
   endtask

   // Monitor: a read accepted on this edge must show its expected data just after it.
   always @(posedge clk) begin
      logic acc;
      acc = (bus.waitrequest === 1'b0) && (bus.read === 1'b1) && !reset;
      if (acc) begin
         #1;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL readdata_unexpected: got 0x%02h with no expected value queued", bus.readdata);
         end else begin
            check("readdata", bus.readdata, exp_q.pop_front());
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("rst_waitrequest", {7'd0, bus.waitrequest}, 8'd1);
      check("rst_readdata", bus.readdata, 8'h00);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("post_rst_waitrequest", {7'd0, bus.waitrequest}, 8'd0);
   endtask

   task automatic access(input logic [7:0] addr, input logic wr, input logic rd,
                         input logic [7:0] wd, input logic [7:0] expd, input logic chk_busy);
      logic got;
      @(negedge clk);
      bus.address   = addr;
      bus.write     = wr;
      bus.read      = rd;
      bus.writedata = wd;
      if (rd) exp_q.push_back(expd);
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         if (bus.waitrequest === 1'b0) begin
            @(posedge clk);
            got = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
      if (!got) begin
         n_checks++;
         n_fail++;
         $display("FAIL accept_timeout: addr 0x%02h not accepted within 20 cycles", addr);
      end
      if (chk_busy) begin
         @(negedge clk);
         bus.write = 1'b0;
         bus.read  = 1'b0;
         check("busy_cycle1", {7'd0, bus.waitrequest}, 8'd1);
         @(negedge clk);
         check("busy_cycle2", {7'd0, bus.waitrequest}, 8'd1);
         @(negedge clk);
         check("busy_end", {7'd0, bus.waitrequest}, 8'd0);
      end
   endtask

   initial begin
      bus.address   = 8'h00;
      bus.write     = 1'b0;
      bus.read      = 1'b0;
      bus.writedata = 8'h00;
      #1 reset = 1'b1;

      do_reset();

      // write then read back
      access(8'h01, 1'b1, 1'b0, 8'd181, 8'h00, 1'b1);
      access(8'h01, 1'b0, 1'b1, 8'h00, 8'd181, 1'b1);

      // simultaneous read+write after fresh reset
      do_reset();
      access(8'h03, 1'b1, 1'b1, 8'd200, 8'd0, 1'b1);
      access(8'h03, 1'b0, 1'b1, 8'h00, 8'd200, 1'b1);

      // overwrite
      access(8'h01, 1'b1, 1'b0, 8'd210, 8'h00, 1'b1);
      access(8'h01, 1'b1, 1'b1, 8'd181, 8'd210, 1'b1);
      access(8'h01, 1'b0, 1'b1, 8'h00, 8'd181, 1'b1);

      // ID, unmapped and map boundaries
      access(8'h00, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b1);
      access(8'h00, 1'b0, 1'b1, 8'h00, 8'h5A, 1'b1);
      access(8'h20, 1'b1, 1'b0, 8'd99, 8'h00, 1'b1);
      access(8'h20, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1);
      access(8'h0F, 1'b1, 1'b0, 8'h33, 8'h00, 1'b1);
      access(8'h0F, 1'b0, 1'b1, 8'h00, 8'h33, 1'b1);
      access(8'h10, 1'b1, 1'b0, 8'h44, 8'h00, 1'b1);
      access(8'h10, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1);

      // reset during BUSY: readdata currently 181 must clear, addr 5 must not survive
      access(8'h01, 1'b0, 1'b1, 8'h00, 8'd181, 1'b1);
      access(8'h05, 1'b1, 1'b0, 8'd181, 8'h00, 1'b0);
      @(negedge clk);
      reset     = 1'b1;
      bus.write = 1'b0;
      bus.read  = 1'b0;
      #1;
      check("midbusy_waitrequest", {7'd0, bus.waitrequest}, 8'd1);
      check("midbusy_readdata", bus.readdata, 8'h00);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("midbusy_release", {7'd0, bus.waitrequest}, 8'd0);
      access(8'h05, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1);

      repeat (4) @(negedge clk);
      check("queue_empty", 8'(exp_q.size()), 8'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
